clic_intreg_bank: RTL

CLIC_INTREG_BANK -- requirements
Module: clic_intreg_bank

---
 rtl/clic_intreg_bank_if.sv | 25 ++
 rtl/clic_intreg_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clic_intreg_bank_if.sv
// rtl/clic_intreg_bank_if.sv - register request/response channel for the CLIC interrupt register bank
interface clic_intreg_bank_if #(
    parameter int AW = 13
);
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic [3:0]    req_wstrb_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_error_o;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/clic_intreg_bank.sv
// rtl/clic_intreg_bank.sv - CLIC cliccfg/clicinfo/per-source register bank with level/edge pending logic
// Optional CLIC_INPUT_SYNC_EN adds a 2-flop synchronizer on every interrupt line.
module clic_intreg_bank #(
    parameter int          N_SOURCE   = 256,
    parameter int          INTCTLBITS = 8,
    parameter logic [7:0]  VERSION    = 8'h01,
    parameter int          AW         = 13,
    localparam int         IDW        = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SOURCE-1:0]      intr_src_i,
    clic_intreg_bank_if.slave        bus,
    input  logic                     ack_valid_i,
    input  logic [IDW-1:0]           ack_id_i,
    output logic [N_SOURCE-1:0]      ip_o,
    output logic [N_SOURCE-1:0]      ie_o,
    output logic [N_SOURCE-1:0]      shv_o,
    output logic [N_SOURCE-1:0][7:0] ctl_o,
    output logic [3:0]               nlbits_o
);
    localparam logic [31:0] SRC_BASE = 32'h1000;
    localparam logic [7:0]  CTL_MASK = 8'(16'hFF00 >> INTCTLBITS);
    localparam logic [31:0] CLICINFO = 32'(N_SOURCE) | (32'(VERSION) << 13) | (32'(INTCTLBITS) << 21);

    logic [N_SOURCE-1:0]      ip_q, ie_q, shv_q, src_in;
    logic [N_SOURCE-1:0][1:0] trig_q;
    logic [N_SOURCE-1:0][7:0] ctl_q;
    logic [3:0]               nlbits_q;
    logic                     rsp_valid_q, rsp_error_q;
    logic [31:0]              rsp_rdata_q;

    logic [31:0]    addr, src_off, rd_data;
    logic [IDW-1:0] src_idx;
    logic           is_cfg, is_info, is_src, dec_err;
    logic           accept, wr_ok, cfg_wr, src_wr, ack_ok;

    always_comb begin
        addr    = 32'(bus.req_addr_i);
        src_off = addr - SRC_BASE;
        src_idx = src_off[IDW+1:2];
        is_cfg  = (addr == 32'h0);
        is_info = (addr == 32'h4);
        is_src  = (addr >= SRC_BASE) && (addr[1:0] == 2'b00) && ((src_off >> 2) < 32'(N_SOURCE));
        dec_err = !(is_cfg || is_src || (is_info && !bus.req_write_i));
    end

    assign bus.req_ready_o = !rsp_valid_q || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign wr_ok           = accept && bus.req_write_i && !dec_err;
    assign cfg_wr          = wr_ok && is_cfg;
    assign src_wr          = wr_ok && is_src;
    assign ack_ok          = ack_valid_i && (32'(ack_id_i) < 32'(N_SOURCE));

    always_comb begin
        rd_data = '0;
        if (is_cfg) begin
            rd_data = {25'd0, 2'b00, nlbits_q, 1'b1};
        end else if (is_info) begin
            rd_data = CLICINFO;
        end else if (is_src) begin
            rd_data = {ctl_q[src_idx], 2'b11, 3'b000, trig_q[src_idx], shv_q[src_idx],
                       7'd0, ie_q[src_idx], 7'd0, ip_q[src_idx]};
        end
    end

    // Write responses and every error response carry zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= dec_err;
            rsp_rdata_q <= (dec_err || bus.req_write_i) ? 32'd0 : rd_data;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_error_o = rsp_error_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nlbits_q <= 4'd0;
        end else if (cfg_wr && bus.req_wstrb_i[0]) begin
            nlbits_q <= (bus.req_wdata_i[4:1] > 4'd8) ? 4'd8 : bus.req_wdata_i[4:1];
        end
    end

`ifdef CLIC_INPUT_SYNC_EN
    logic [N_SOURCE-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= intr_src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_in = sync_q2;
`else
    assign src_in = intr_src_i;
`endif

    for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
        logic       hit, ack_hit, active, edge_det;
        logic       ip_r, ie_r, shv_r, prev_r;
        logic [1:0] trig_r;
        logic [7:0] ctl_r;

        assign hit     = src_wr && (src_idx == IDW'(i));
        assign ack_hit = ack_ok && (ack_id_i == IDW'(i));
        // prev_r holds the raw line, so polarity is applied to both samples with the
        // current trig; a trig change therefore never manufactures an edge.
        assign active   = src_in[i] ^ trig_r[1];
        assign edge_det = active && !(prev_r ^ trig_r[1]);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ip_r   <= 1'b0;
                ie_r   <= 1'b0;
                shv_r  <= 1'b0;
                prev_r <= 1'b0;
                trig_r <= 2'b00;
                ctl_r  <= ~CTL_MASK;
            end else begin
                prev_r <= src_in[i];
                if (!trig_r[0]) begin
                    ip_r <= active;
                end else if (edge_det) begin
                    ip_r <= 1'b1;
                end else if (hit && bus.req_wstrb_i[0]) begin
                    ip_r <= bus.req_wdata_i[0];
                end else if (ack_hit) begin
                    ip_r <= 1'b0;
                end
                if (hit && bus.req_wstrb_i[1]) begin
                    ie_r <= bus.req_wdata_i[8];
                end
                if (hit && bus.req_wstrb_i[2]) begin
                    shv_r  <= bus.req_wdata_i[16];
                    trig_r <= bus.req_wdata_i[18:17];
                end
                if (hit && bus.req_wstrb_i[3]) begin
                    ctl_r <= (bus.req_wdata_i[31:24] & CTL_MASK) | ~CTL_MASK;
                end
            end
        end

        assign ip_q[i]   = ip_r;
        assign ie_q[i]   = ie_r;
        assign shv_q[i]  = shv_r;
        assign trig_q[i] = trig_r;
        assign ctl_q[i]  = ctl_r;
    end

    assign ip_o     = ip_q;
    assign ie_o     = ie_q;
    assign shv_o    = shv_q;
    assign ctl_o    = ctl_q;
    assign nlbits_o = nlbits_q;
endmodule
